// File: rtl/button_pulse_conditioner_if.sv
// ---------------------------------------------------------------------------
// button_pulse_conditioner_if
//
// Bundles the pushbutton-side and FSM-side signals of the button conditioner.
//
//   btn_raw    raw pushbutton level, asynchronous to the consumer clock
//   x          one-cycle press / repeat pulse (downstream FSM serial input)
//   level      debounced pressed level, 1 = pressed
//   repeating  high while the conditioner is auto-repeating
//
// Modports:
//   master  - the side that owns the button and watches the results
//   slave   - the conditioner itself
// ---------------------------------------------------------------------------
interface button_pulse_conditioner_if;
    logic btn_raw;
    logic x;
    logic level;
    logic repeating;

    modport master (
        output btn_raw,
        input  x,
        input  level,
        input  repeating
    );

    modport slave (
        input  btn_raw,
        output x,
        output level,
        output repeating
    );
endinterface

// File: rtl/button_pulse_conditioner.sv
// ---------------------------------------------------------------------------
// button_pulse_conditioner
//
// Turns a raw, bouncy, asynchronous pushbutton into clean single-cycle pulses
// for a single-input Moore FSM: 2-flop synchronizer -> debounce -> press
// pulse -> optional auto-repeat while the button stays held.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   button_pulse_conditioner_if.slave
//           btn_raw   (in)  raw pushbutton
//           x         (out) one-cycle press / repeat pulse
//           level     (out) debounced pressed level, 1 = pressed
//           repeating (out) high while in the REPEAT state
//
// All outputs are registered. The pulse FSM is steered by the level value
// being loaded on the same edge, so the press pulse starts together with
// the debounced level and a release that lands on a repeat expiry wins.
// ---------------------------------------------------------------------------
module button_pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    button_pulse_conditioner_if.slave    bus
);

    // Raw value of an idle (not-pressed) button.
    localparam logic NOT_PRESSED = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int T_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TM_W  = $clog2(T_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TM_W-1:0] DELAY_LAST  = TM_W'(REPEAT_DELAY - 1);
    localparam logic [TM_W-1:0] PERIOD_LAST = TM_W'(REPEAT_PERIOD - 1);
    localparam logic [TM_W-1:0] TIMER_SAT   = {TM_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Synchronizer. Both flops reset to the idle level so a reset never
    // looks like a press.
    // -----------------------------------------------------------------------
    logic [1:0] sync_reg;
    logic       pressed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= {2{NOT_PRESSED}};
        end else begin
            sync_reg <= {sync_reg[0], bus.btn_raw};
        end
    end

    // Polarity fold: pressed = 1 whenever the button is down.
    assign pressed = sync_reg[1] ^ NOT_PRESSED;

    // -----------------------------------------------------------------------
    // Debounce: the counter only runs while the synchronized input disagrees
    // with the accepted level; any agreeing cycle throws the run away.
    // -----------------------------------------------------------------------
    logic [DB_W-1:0] db_cnt_reg, db_cnt_next;
    logic            level_reg,  level_next;

    always_comb begin
        db_cnt_next = '0;
        level_next  = level_reg;
        if (pressed != level_reg) begin
            if (db_cnt_reg == DB_LAST) begin
                level_next = ~level_reg;
            end else begin
                db_cnt_next = db_cnt_reg + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_reg <= '0;
            level_reg  <= 1'b0;
        end else begin
            db_cnt_reg <= db_cnt_next;
            level_reg  <= level_next;
        end
    end

    // -----------------------------------------------------------------------
    // Pulse FSM.
    // -----------------------------------------------------------------------
    state_t          state_reg, state_next;
    logic [TM_W-1:0] timer_reg, timer_next;
    logic            x_reg, x_next;
    logic            repeating_reg, repeating_next;
    logic [TM_W-1:0] timer_inc;

    // Saturating increment: a long hold with repeat disabled must not wrap.
    assign timer_inc = (timer_reg == TIMER_SAT) ? timer_reg : timer_reg + TM_W'(1);

    always_comb begin
        state_next     = state_reg;
        timer_next     = timer_reg;
        x_next         = 1'b0;
        repeating_next = 1'b0;

        if (!level_next) begin
            // Release (or still idle) overrides everything, including a
            // repeat that would have expired on this very edge.
            state_next = IDLE;
            timer_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Only reachable with level rising on this edge.
                    x_next     = ~level_reg;
                    timer_next = '0;
                    state_next = HELD;
                end
                HELD: begin
                    if ((REPEAT_EN != 0) && (timer_reg == DELAY_LAST)) begin
                        x_next         = 1'b1;
                        timer_next     = '0;
                        state_next     = REPEAT;
                        repeating_next = 1'b1;
                    end else begin
                        timer_next = timer_inc;
                    end
                end
                REPEAT: begin
                    repeating_next = 1'b1;
                    if (timer_reg == PERIOD_LAST) begin
                        x_next     = 1'b1;
                        timer_next = '0;
                    end else begin
                        timer_next = timer_inc;
                    end
                end
                default: begin
                    state_next = IDLE;
                    timer_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            timer_reg     <= '0;
            x_reg         <= 1'b0;
            repeating_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            x_reg         <= x_next;
            repeating_reg <= repeating_next;
        end
    end

    assign bus.x         = x_reg;
    assign bus.level     = level_reg;
    assign bus.repeating = repeating_reg;

endmodule

// File: tb/tb_button_pulse_conditioner.sv
module tb_button_pulse_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    button_pulse_conditioner_if if0();
    button_pulse_conditioner_if if1();

    // The repeat-disabled instance watches the same button.
    assign if1.btn_raw = if0.btn_raw;

    button_pulse_conditioner #(
        .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1), .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP), .ACTIVE_LOW(1)
    ) dut_rep (
        .clk(clk), .rst(rst), .bus(if0)
    );

    button_pulse_conditioner #(
        .DEBOUNCE_CYCLES(DB), .REPEAT_EN(0), .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP), .ACTIVE_LOW(1)
    ) dut_norep (
        .clk(clk), .rst(rst), .bus(if1)
    );

    // Downstream FSM (00 -> 01 -> 11 -> 00 on each x); b flags the 01->11 move.
    logic [1:0] ds_state;
    logic       ds_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ds_state <= 2'b00;
            ds_b     <= 1'b0;
        end else begin
            ds_b <= 1'b0;
            if (if0.x) begin
                case (ds_state)
                    2'b00:   ds_state <= 2'b01;
                    2'b01: begin
                        ds_state <= 2'b11;
                        ds_b     <= 1'b1;
                    end
                    default: ds_state <= 2'b00;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    int x0_cnt, x1_cnt, b_cnt, b_edge;
    bit rep0_seen, rep1_seen, lvl0_seen;
    int x_edges[$];

    // ------------------------------------------------------------------
    // Reference model: history based. Level flips when the last DB
    // synchronized samples all disagree with it; pulses are placed by
    // arithmetic on the distance from the press edge.
    // ------------------------------------------------------------------
    bit m_sync[$];
    bit m_win[$];
    bit m_level, m_x, m_rep;
    int m_edge, m_rise;

    function automatic void model_reset();
        m_sync.delete();
        m_sync.push_back(1'b0);
        m_sync.push_back(1'b0);
        m_win.delete();
        m_level = 1'b0;
        m_x     = 1'b0;
        m_rep   = 1'b0;
        m_edge  = 0;
        m_rise  = -1;
    endfunction

    function automatic void model_edge(input logic raw);
        bit p_now;
        bit flip;
        int d;
        p_now = m_sync.pop_front();
        m_sync.push_back(~raw);
        m_win.push_back(p_now);
        if (m_win.size() > DB) void'(m_win.pop_front());
        flip = (m_win.size() == DB);
        foreach (m_win[i]) if (m_win[i] == m_level) flip = 1'b0;
        if (flip) m_level = ~m_level;
        if (!m_level) begin
            m_x = 1'b0; m_rep = 1'b0; m_rise = -1;
        end else if (flip) begin
            m_x = 1'b1; m_rep = 1'b0; m_rise = m_edge;
        end else begin
            d     = m_edge - m_rise;
            m_x   = (d == RD) || ((d > RD) && ((d - RD) % RP == 0));
            m_rep = (d >= RD);
        end
        m_edge++;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (edge %0d, t=%0t)", name, act, exp, m_edge - 1, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_counts();
        x0_cnt = 0; x1_cnt = 0; b_cnt = 0; b_edge = -1;
        rep0_seen = 0; rep1_seen = 0; lvl0_seen = 0;
        x_edges.delete();
    endtask

    // One clock: drive raw, let the edge happen, check against the model.
    task automatic step(input logic raw);
        if0.btn_raw = raw;
        @(posedge clk);
        #1;
        model_edge(raw);
        check("x", if0.x, m_x);
        check("level", if0.level, m_level);
        check("repeating", if0.repeating, m_rep);
        if (if0.x) begin
            x0_cnt++;
            x_edges.push_back(m_edge - 1);
        end
        if (if1.x) x1_cnt++;
        if (if0.repeating) rep0_seen = 1;
        if (if1.repeating) rep1_seen = 1;
        if (if0.level) lvl0_seen = 1;
        if (ds_b) begin
            b_cnt++;
            b_edge = m_edge - 1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        check("async_rst_x", if0.x, 1'b0);
        check("async_rst_level", if0.level, 1'b0);
        check("async_rst_repeating", if0.repeating, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        clear_counts();
    endtask

    typedef struct {
        logic raw;
        logic ex;
        logic el;
        logic er;
    } vec_t;

    vec_t vt[26];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        if0.btn_raw = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_x", if0.x, 1'b0);
        check("reset_level", if0.level, 1'b0);
        check("reset_repeating", if0.repeating, 1'b0);
        rst = 1'b0;
        model_reset();
        clear_counts();

        // ---- 1. clean press, table driven ----
        for (int i = 0; i < 26; i++) begin
            vt[i].raw = (i < 20) ? 1'b0 : 1'b1;
            vt[i].el  = (i >= 5) && (i < 25);
            vt[i].er  = (i >= 15) && (i < 25);
            vt[i].ex  = (i == 5) || (i == 15) || (i == 18) || (i == 21) || (i == 24);
        end
        for (int i = 0; i < 26; i++) begin
            step(vt[i].raw);
            check("tbl_x", if0.x, vt[i].ex);
            check("tbl_level", if0.level, vt[i].el);
            check("tbl_repeating", if0.repeating, vt[i].er);
            $display("vec %0d raw=%b x=%b level=%b repeating=%b", i, vt[i].raw, if0.x, if0.level, if0.repeating);
        end
        repeat (6) step(1'b1);

        // ---- 2. bounce rejection ----
        clear_counts();
        repeat (3) step(1'b0);
        repeat (2) step(1'b1);
        repeat (3) step(1'b0);
        repeat (10) step(1'b1);
        check("bounce_level_seen", lvl0_seen, 1'b0);
        check_int("bounce_x_count", x0_cnt, 0);
        $display("bounce: x pulses=%0d level_seen=%0d", x0_cnt, lvl0_seen);

        // ---- 3. release races the first repeat ----
        do_reset();
        repeat (10) step(1'b0);
        repeat (20) step(1'b1);
        check_int("race_x_count", x0_cnt, 1);
        check("race_repeating_seen", rep0_seen, 1'b0);
        $display("race: x pulses=%0d repeating_seen=%0d", x0_cnt, rep0_seen);

        // ---- 4. repeat disabled ----
        do_reset();
        repeat (100) step(1'b0);
        check_int("norep_x_count", x1_cnt, 1);
        check("norep_repeating_seen", rep1_seen, 1'b0);
        check_int("rep_x_count", x0_cnt, 30);
        repeat (10) step(1'b1);
        $display("norep: x pulses=%0d (repeat instance %0d)", x1_cnt, x0_cnt);

        // ---- 5. reset mid-hold ----
        do_reset();
        repeat (20) step(1'b0);
        check("hold_in_repeat", if0.repeating, 1'b1);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0);
            check("post_rst_no_pulse", if0.x, 1'b0);
        end
        step(1'b0);
        check("post_rst_press_pulse", if0.x, 1'b1);
        repeat (12) step(1'b1);
        $display("reset mid-hold: press pulse after 6 cycles x=%0d", x0_cnt);

        // ---- 6. downstream FSM integration ----
        do_reset();
        for (int k = 0; k < 3; k++) begin
            repeat (8) step(1'b0);
            repeat (12) step(1'b1);
        end
        check_int("ds_x_count", x0_cnt, 3);
        check_int("ds_b_count", b_cnt, 1);
        if (x_edges.size() >= 2) check_int("ds_b_edge", b_edge, x_edges[1] + 1);
        else check_int("ds_x_edges", x_edges.size(), 3);
        check_int("ds_final_state", int'(ds_state), 0);
        $display("downstream: b pulses=%0d at edge %0d", b_cnt, b_edge);

        // ---- 7. randomized against the reference model ----
        do_reset();
        for (int burst = 0; burst < 80; burst++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = (($urandom_range(0, 3)) == 0) ? int'($urandom_range(20, 40)) : int'($urandom_range(1, 8));
            for (int c = 0; c < len; c++) step(v);
            if ($urandom_range(0, 29) == 0) do_reset();
        end
        $display("random: done at edge %0d", m_edge);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
